// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates one single-port RAM between an icache and a dcache.
//
// dcache requests win over icache requests. A grant is held until the RAM
// reports ACCESS (completion) or the owner drops its request. A winner is
// always registered through one IDLE cycle, so back-to-back grants are
// separated by a single idle cycle.
//
// Optional build macro ARB_STARVE_GUARD_EN: after STARVE_MAX consecutive
// dcache completions while the icache is waiting, the icache is forced to
// win the next arbitration.
//
// Ports:
//   CLK, nRST                     clock, async active-low reset
//   iREN, iaddr -> iwait, iload   icache read port
//   dREN, dWEN, daddr, dstore     dcache request
//   dwait, dload                  dcache stall / read data
//   ramREN, ramWEN, ramaddr,
//   ramstore                      RAM command
//   ramload, ramstate             RAM read data / status (00 FREE, 01 BUSY,
//                                 10 ACCESS, 11 ERROR)
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

  localparam logic [1:0] RS_ACCESS = 2'b10;

  // The starvation counter is 3 bits wide, so the limit must fit in it.
  if (STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_bad_starve_max
    $error("mem_arbiter: STARVE_MAX must be in 1..7");
  end

  state_t state, state_n;
  logic   dreq, access, i_done, d_done, i_force;

  assign dreq   = dREN | dWEN;
  assign access = (ramstate == RS_ACCESS);
  // Completion needs the owner still requesting; a dropped request never
  // reports a completion even if the RAM says ACCESS that cycle.
  assign i_done = (state == IGNT) & iREN & access;
  assign d_done = (state == DGNT) & dreq & access;

`ifdef ARB_STARVE_GUARD_EN
  logic [2:0] starve_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      starve_cnt <= '0;
    else if (i_done || (state == IDLE && !iREN))
      starve_cnt <= '0;
    else if (d_done && iREN && starve_cnt != 3'd7)
      starve_cnt <= starve_cnt + 3'd1;
  end

  assign i_force = iREN & (starve_cnt == 3'(STARVE_MAX));
`else
  assign i_force = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      IDLE: begin
        if (dreq && !i_force) state_n = DGNT;
        else if (iREN)        state_n = IGNT;
      end
      IGNT: begin
        if (iREN) begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
        end
        if (!iREN || access) state_n = IDLE;
      end
      DGNT: begin
        // Write wins when the dcache raises both enables.
        if (dreq) begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = ~dWEN;
        end
        if (!dreq || access) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign iwait = iREN & ~i_done;
  assign dwait = dreq & ~d_done;
  assign iload = i_done ? ramload : '0;
  assign dload = d_done ? ramload : '0;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive dcache grants allowed while an icache request waits (guard build only).
REQ-002 CLK  in  1  system clock; all state updates on the rising edge.
REQ-003 nRST  in  1  reset, asynchronous and active-low.
REQ-004 iREN  in  1  icache read request; iaddr  in  32  icache word address.
REQ-005 iwait  out  1  icache stall; iload  out  32  icache read data.
REQ-006 dREN  in  1  dcache read request; dWEN  in  1  dcache write request.
REQ-007 daddr  in  32  dcache address; dstore  in  32  dcache write data.
REQ-008 dwait  out  1  dcache stall; dload  out  32  dcache read data.
REQ-009 ramREN  out  1, ramWEN  out  1, ramaddr  out  32, ramstore  out  32: single-port RAM command.
REQ-010 ramload  in  32  RAM read data.
REQ-011 ramstate  in  2  RAM status: 00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR.

Function
REQ-012 FSM states IDLE, IGNT, DGNT; one requester owns the RAM at a time.
- IDLE: drives no RAM command; arbitrates; the winner is registered into IGNT or DGNT on the next edge.
- Arbitration: dcache (dREN|dWEN) beats icache (iREN), unless the starvation guard forces icache (REQ-022).
REQ-013 IGNT: ramREN=1, ramWEN=0, ramaddr=iaddr.
REQ-014 DGNT: ramaddr=daddr, ramstore=dstore.
- dWEN=1: ramWEN=1, ramREN=0. dWEN has priority when dREN and dWEN are both high.
- dWEN=0: ramREN=1.
REQ-015 Grant held while ramstate is FREE, BUSY or ERROR.
- ERROR: command is reissued unchanged; the requester stays stalled.
REQ-016 Grant completes in the cycle ramstate=ACCESS.
- Owner's wait=0 for exactly that cycle; iload/dload = ramload combinationally.
- FSM returns to IDLE on the next edge.
REQ-017 Completion latency:
- Minimum 2 cycles from request rise to wait low (arbitration cycle + ACCESS cycle).
- Back-to-back grants are separated by one IDLE cycle.
REQ-018 iwait = iREN & ~(IGNT & ramstate==ACCESS); dwait = (dREN|dWEN) & ~(DGNT & ramstate==ACCESS).
REQ-019 Owner deasserts its request while granted: RAM command drops the same cycle; FSM goes to IDLE on the next edge; no completion is reported.
REQ-020 Non-owner outputs: iload and dload are 0 whenever that port is not completing.

Reset
REQ-021 nRST low:
- FSM = IDLE, starvation counter = 0.
- ramREN = ramWEN = 0, ramaddr = ramstore = 0.
- iwait/dwait follow REQ-018 (high while requested); iload = dload = 0.
- Reset mid-grant abandons the access with no completion.

Configuration
REQ-022 ARB_STARVE_GUARD_EN defined:
- A 3-bit saturating counter increments on each DGNT completion while iREN=1.
- The counter clears on any IGNT completion, or whenever iREN=0 in IDLE.
- When counter == STARVE_MAX in IDLE with iREN=1, icache wins regardless of dcache requests.
REQ-023 ARB_STARVE_GUARD_EN undefined: strict dcache priority; no counter is present.

Verification
REQ-024 iREN=1 iaddr=0x40, ramstate=ACCESS, ramload=0xDEADBEEF -> ramREN=1 on cycle 2, iwait=0, iload=0xDEADBEEF on cycle 2, IDLE on cycle 3.
REQ-025 iREN and dWEN rise together, daddr=0x80, dstore=0x1234 -> DGNT first with ramWEN=1, ramstore=0x1234; IGNT follows after one IDLE cycle.
REQ-026 dREN held, ramstate=BUSY,BUSY,ERROR,ACCESS -> dwait=1 for three cycles, then 0 on the ACCESS cycle; ramaddr stable throughout.
REQ-027 Guard enabled, STARVE_MAX=4, iREN and dREN held continuously -> 4 DGNT completions, then 1 IGNT, then dcache again; guard disabled -> IGNT never occurs.
REQ-028 nRST pulsed low during DGNT with ramstate=BUSY -> ramWEN/ramREN=0 immediately, FSM=IDLE, no dwait=0 pulse.
REQ-029 iREN dropped in IGNT before ACCESS -> ramREN=0 the same cycle, IDLE on the next edge, iwait=0, iload=0.
